// File: rtl/snn_config_loader_pkg.sv
// Shared constants for the SNN configuration loader: address map, bus widths, FSM encoding.
package snn_cfg_pkg;
  localparam int W_BITS = 256;
  localparam int D_BITS = 512;

  localparam logic [6:0] ADDR_W_BASE  = 7'd0;
  localparam logic [6:0] ADDR_D_BASE  = 7'd32;
  localparam logic [6:0] ADDR_THR_DEC = 7'd96;
  localparam logic [6:0] ADDR_REFRAC  = 7'd97;
  localparam logic [6:0] ADDR_LAST    = 7'd97;
  localparam logic [6:0] ADDR_MAX     = 7'd127;

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE} cfg_state_e;

  // Auto-increment that sticks at the top of the space instead of wrapping.
  function automatic logic [6:0] addr_next(input logic [6:0] a);
    return (a == ADDR_MAX) ? a : a + 7'd1;
  endfunction
endpackage

// File: rtl/snn_config_loader_if.sv
// Byte-stream handshake from the chip I/O front end into the config loader.
interface snn_config_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/snn_config_loader_timeout.sv
// Inter-byte idle counter; expires after TIMEOUT consecutive enabled cycles without a clear.
module snn_cfg_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i)                cnt_d = '0;
    else if (cnt_q != CW'(TIMEOUT))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT));
endmodule

// File: rtl/snn_config_loader.sv
// Byte-serial configuration writer: header/length/payload frames into the packed SNN config buses.
module snn_config_loader
  import snn_cfg_pkg::*;
#(
  parameter int         TIMEOUT    = 255,
  parameter logic [4:0] THRESH_RST = 5'd8,
  parameter logic [2:0] DECAY_RST  = 3'd1,
  parameter logic [4:0] REFRAC_RST = 5'd2
) (
  input  logic                clk,
  input  logic                reset_n,
  snn_config_loader_if.slave  in_if,
  output logic [W_BITS-1:0]   weights,
  output logic [D_BITS-1:0]   delays,
  output logic [4:0]          threshold,
  output logic [2:0]          decay,
  output logic [4:0]          refractory_period,
  output logic                cfg_busy,
  output logic                cfg_update,
  output logic                cfg_error
);
  cfg_state_e        state_q, state_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [D_BITS-1:0] dly_q, dly_d;
  logic [4:0]        thr_q, thr_d, ref_q, ref_d;
  logic [2:0]        dec_q, dec_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic              accept, in_frame, expire;
  logic [5:0]        doff;

  assign in_if.in_ready = rdy_q && (state_q != ST_DONE);
  assign accept   = in_if.in_valid && in_if.in_ready;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA);
  // Delay region starts at 32, so the 6-bit offset is just the low address bits minus 32 mod 64.
  assign doff     = addr_q[5:0] - ADDR_D_BASE[5:0];

  snn_cfg_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (accept),
    .en_i     (in_frame),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    dly_d   = dly_q;
    thr_d   = thr_q;
    dec_d   = dec_q;
    ref_d   = ref_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_if.in_data[7]) begin
          addr_d  = in_if.in_data[6:0];
          err_d   = 1'b0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          cnt_d   = in_if.in_data;
          state_d = (in_if.in_data == 8'd0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          if (addr_q > ADDR_LAST)          err_d = 1'b1;
          else if (addr_q < ADDR_D_BASE)   w_d[{addr_q[4:0], 3'b000} +: 8] = in_if.in_data;
          else if (addr_q < ADDR_THR_DEC)  dly_d[{doff, 3'b000} +: 8] = in_if.in_data;
          else if (addr_q == ADDR_THR_DEC) {dec_d, thr_d} = in_if.in_data;
          else                             ref_d = in_if.in_data[4:0];
          addr_d = addr_next(addr_q);
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      dly_q   <= '0;
      thr_q   <= THRESH_RST;
      dec_q   <= DECAY_RST;
      ref_q   <= REFRAC_RST;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      dly_q   <= dly_d;
      thr_q   <= thr_d;
      dec_q   <= dec_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign weights           = w_q;
  assign delays            = dly_q;
  assign threshold         = thr_q;
  assign decay             = dec_q;
  assign refractory_period = ref_q;
  assign cfg_busy          = (state_q != ST_IDLE);
  assign cfg_update        = (state_q == ST_DONE);
  assign cfg_error         = err_q;
endmodule
